mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-port, byte-wide, synchronous memory between the f8 core's three access ports: instruction fetch (24-bit), data read (16-bit) and data write (16-bit).
- Arbitrates between pending requests and sequences each granted request as consecutive byte accesses.
- Assembles and disassembles multi-byte words little-endian.
- Sits between cpu and a byte-wide memory in testsystem. Replaces the current three-port memory model.

Parameters:
- ADDR_W, 16, width of every address port; byte addresses wrap modulo 2^ADDR_W.
- IFETCH_BYTES, 3, bytes per instruction fetch; i_data width is 8*IFETCH_BYTES.
- DATA_BYTES, 2, bytes per data read or write; data widths are 8*DATA_BYTES.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held with i_addr stable until i_valid.
- i_addr  in  ADDR_W  fetch byte address.
- i_data  out  24  fetched bytes; addr in [7:0].
- i_valid  out  1  one-cycle fetch response.
- d_rd_req  in  1  data read request.
- d_rd_addr  in  ADDR_W  data read address.
- d_rd_data  out  16  read result, little-endian.
- d_rd_valid  out  1  one-cycle read response.
- d_wr_req  in  1  data write request.
- d_wr_addr  in  ADDR_W  data write address.
- d_wr_data  in  16  write data, little-endian.
- d_wr_done  out  1  one-cycle write completion.
- mem_en  out  1  memory strobe.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte; valid the cycle after its strobe.

Behaviour:
- Reset (asynchronous, active-low):
  - FSM goes to IDLE.
  - All outputs are 0, including i_data and d_rd_data.
  - Any in-flight transaction is dropped; no response pulse is issued for it.
- FSM states: IDLE, ISSUE, DRAIN, RESP.
- IDLE:
  - If any request is pending at a rising edge, that edge is the grant edge G.
  - At G, latch the winner, its address and, for writes, its data.
  - Byte counter k := 0. Go to ISSUE.
- Fixed priority (default): d_wr > d_rd > i.
- ISSUE:
  - Registered outputs in cycles G..G+N-1: mem_en=1, mem_addr = addr+k (ADDR_W wrap), mem_we=1 for writes only, mem_wdata = byte k of the latched data.
  - N = IFETCH_BYTES for fetches, DATA_BYTES for data accesses.
  - After byte N-1: reads go to DRAIN; writes go to RESP.
- Reads:
  - mem_rdata is captured into byte k-1 of an assembly register each cycle.
  - DRAIN lasts one cycle and captures the final byte.
  - Response (i_valid or d_rd_valid) is high for exactly one cycle, G+N+1.
  - i_data / d_rd_data are updated only at the response and held until the next response from the same port.
- Writes: d_wr_done is high for one cycle, G+N.
- RESP lasts one cycle and then returns to IDLE. A request that is high at the edge ending RESP may be granted there; the address present at that edge is used, so no bubble occurs.
- Never more than one transaction in flight. Exactly one response per grant.
- Requests arriving during a transaction wait. Losing requesters are not acknowledged.
- Dropping req before the response does not abort a granted transaction; the response still pulses.
- Simultaneous write and read to the same address: the write is granted first, so the read returns the new data.
- mem_en is 0 in IDLE, DRAIN and RESP.

Optional Feature:
- Macro: MEM_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - Rotating priority over the order wr, rd, i.
  - A last-grant pointer is updated at each grant; the requester after the last winner has highest priority.
  - Pointer resets to i, so the first contention goes to wr.
- Undefined: fixed priority d_wr > d_rd > i; no pointer register.

Decomposition:
- Package mem_arbiter_pkg holds:
  - state enum (IDLE, ISSUE, DRAIN, RESP)
  - requester id enum (REQ_I, REQ_RD, REQ_WR)
  - byte-count constants
- One sub-module, mem_arbiter_pick: combinational winner selection from three request bits and, under the macro, the last-grant pointer.

Test Plan:
- Fetch: mem[0x0100..0x0102] = 11,22,33; i_req at 0x0100 -> three strobes at 0x0100/0x0101/0x0102; i_valid at G+4 with i_data = 0x332211.
- Write then read: d_wr 0xBEEF to 0x2000 -> mem_we bytes EF then BE; d_wr_done at G+2. Then d_rd 0x2000 -> d_rd_data = 0xBEEF at G+3.
- Wrap: d_rd at 0xFFFF, mem[0xFFFF] = 0x34, mem[0x0000] = 0x12 -> mem_addr FFFF then 0000; d_rd_data = 0x1234.
- Contention: i, rd and wr raised on the same edge and held -> grants in order wr, rd, i; responses back-to-back with no idle cycle between transactions.
- Reset mid-operation: pull reset low in cycle G+1 of a fetch -> mem_en=0 immediately, i_valid never pulses, FSM in IDLE. After release, a new fetch completes normally.
- With MEM_ARBITER_ROUND_ROBIN_EN: rd and i held continuously -> grants alternate rd, i, rd, i. Without the macro, i starves while rd is held.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default sizes for the byte-wide memory arbiter.
// The state and requester enums are used by mem_arbiter and mem_arbiter_pick.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REQ_I  = 2'd0,
        REQ_RD = 2'd1,
        REQ_WR = 2'd2
    } req_id_t;

    localparam int ADDR_W_DEF       = 16;
    localparam int IFETCH_BYTES_DEF = 3;
    localparam int DATA_BYTES_DEF   = 2;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection among fetch, data-read and data-write requests.
// Fixed priority wr > rd > i; with MEM_ARBITER_ROUND_ROBIN_EN priority rotates after `last`.
module mem_arbiter_pick
    import mem_arbiter_pkg::*;
(
    input  logic       i_req,
    input  logic       rd_req,
    input  logic       wr_req,
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    input  logic [1:0] last,
`endif
    output logic       any,
    output logic [1:0] winner
);

    always_comb begin
        any    = i_req | rd_req | wr_req;
        winner = REQ_I;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        // The requester following the previous winner in the ring wr -> rd -> i goes first.
        case (last)
            REQ_WR: begin
                if (rd_req)      winner = REQ_RD;
                else if (i_req)  winner = REQ_I;
                else if (wr_req) winner = REQ_WR;
            end
            REQ_RD: begin
                if (i_req)       winner = REQ_I;
                else if (wr_req) winner = REQ_WR;
                else if (rd_req) winner = REQ_RD;
            end
            default: begin
                if (wr_req)      winner = REQ_WR;
                else if (rd_req) winner = REQ_RD;
                else if (i_req)  winner = REQ_I;
            end
        endcase
`else
        if (wr_req)      winner = REQ_WR;
        else if (rd_req) winner = REQ_RD;
        else if (i_req)  winner = REQ_I;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-wide synchronous memory between instruction fetch, data read and data write.
// Optional rotating priority is enabled by defining MEM_ARBITER_ROUND_ROBIN_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int IFETCH_BYTES = IFETCH_BYTES_DEF,
    parameter int DATA_BYTES   = DATA_BYTES_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_req,
    input  logic [ADDR_W-1:0]         i_addr,
    output logic [8*IFETCH_BYTES-1:0] i_data,
    output logic                      i_valid,
    input  logic                      d_rd_req,
    input  logic [ADDR_W-1:0]         d_rd_addr,
    output logic [8*DATA_BYTES-1:0]   d_rd_data,
    output logic                      d_rd_valid,
    input  logic                      d_wr_req,
    input  logic [ADDR_W-1:0]         d_wr_addr,
    input  logic [8*DATA_BYTES-1:0]   d_wr_data,
    output logic                      d_wr_done,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [7:0]                mem_wdata,
    input  logic [7:0]                mem_rdata
);

    localparam int MAX_BYTES = (IFETCH_BYTES > DATA_BYTES) ? IFETCH_BYTES : DATA_BYTES;
    localparam int CNT_W     = (MAX_BYTES > 2) ? $clog2(MAX_BYTES) : 1;
    localparam int ASM_W     = 8 * MAX_BYTES;

    state_t                    state_reg, state_next;
    logic [CNT_W-1:0]          k_reg, k_next, last_k, cap_idx;
    req_id_t                   who_reg, who_next, grant_id;
    logic [ADDR_W-1:0]         addr_reg, addr_next, grant_addr, mem_addr_next;
    logic [ASM_W-1:0]          wdata_reg, wdata_next, asm_reg, asm_next;
    logic                      grant_any, grant, strobe, cap_en;
    logic                      mem_en_next, mem_we_next;
    logic                      i_valid_next, d_rd_valid_next, d_wr_done_next;
    logic [7:0]                mem_wdata_next;
    logic [8*IFETCH_BYTES-1:0] i_data_next;
    logic [8*DATA_BYTES-1:0]   d_rd_data_next;
    logic [1:0]                winner_bits;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    req_id_t last_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     last_reg <= REQ_I;
        else if (grant) last_reg <= grant_id;
    end
`endif

    mem_arbiter_pick u_pick (
        .i_req  (i_req),
        .rd_req (d_rd_req),
        .wr_req (d_wr_req),
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        .last   (last_reg),
`endif
        .any    (grant_any),
        .winner (winner_bits)
    );

    assign grant_id = req_id_t'(winner_bits);
    // Granting from RESP as well as IDLE keeps back-to-back transactions bubble-free.
    assign grant    = grant_any && (state_reg == IDLE || state_reg == RESP);
    assign last_k   = (who_reg == REQ_I) ? CNT_W'(IFETCH_BYTES - 1) : CNT_W'(DATA_BYTES - 1);

    always_comb begin
        case (grant_id)
            REQ_WR:  grant_addr = d_wr_addr;
            REQ_RD:  grant_addr = d_rd_addr;
            default: grant_addr = i_addr;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        k_next          = k_reg;
        who_next        = who_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        asm_next        = asm_reg;
        mem_en_next     = 1'b0;
        mem_we_next     = 1'b0;
        mem_addr_next   = '0;
        mem_wdata_next  = 8'h00;
        i_valid_next    = 1'b0;
        d_rd_valid_next = 1'b0;
        d_wr_done_next  = 1'b0;
        i_data_next     = i_data;
        d_rd_data_next  = d_rd_data;
        strobe          = 1'b0;
        cap_en          = 1'b0;
        cap_idx         = '0;

        case (state_reg)
            IDLE, RESP: begin
                if (grant) begin
                    who_next   = grant_id;
                    addr_next  = grant_addr;
                    wdata_next = (grant_id == REQ_WR) ? ASM_W'(d_wr_data) : '0;
                    k_next     = '0;
                    strobe     = 1'b1;
                    state_next = ISSUE;
                end else begin
                    state_next = IDLE;
                end
            end
            ISSUE: begin
                // Memory returns the byte strobed one cycle earlier.
                if (k_reg != '0) begin
                    cap_en  = 1'b1;
                    cap_idx = k_reg - CNT_W'(1);
                end
                if (k_reg == last_k) begin
                    state_next     = (who_reg == REQ_WR) ? RESP : DRAIN;
                    d_wr_done_next = (who_reg == REQ_WR);
                end else begin
                    k_next = k_reg + CNT_W'(1);
                    strobe = 1'b1;
                end
            end
            DRAIN: begin
                cap_en     = 1'b1;
                cap_idx    = last_k;
                state_next = RESP;
            end
            default: state_next = IDLE;
        endcase

        if (strobe) begin
            mem_en_next   = 1'b1;
            mem_we_next   = (who_next == REQ_WR);
            mem_addr_next = addr_next + ADDR_W'(k_next);
        end

        for (int b = 0; b < MAX_BYTES; b++) begin
            if (strobe && k_next == CNT_W'(b))  mem_wdata_next      = wdata_next[8*b +: 8];
            if (cap_en && cap_idx == CNT_W'(b)) asm_next[8*b +: 8] = mem_rdata;
        end

        if (state_reg == DRAIN) begin
            if (who_reg == REQ_I) begin
                i_valid_next = 1'b1;
                i_data_next  = asm_next[8*IFETCH_BYTES-1:0];
            end else begin
                d_rd_valid_next = 1'b1;
                d_rd_data_next  = asm_next[8*DATA_BYTES-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            k_reg      <= '0;
            who_reg    <= REQ_I;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            asm_reg    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'h00;
            i_valid    <= 1'b0;
            d_rd_valid <= 1'b0;
            d_wr_done  <= 1'b0;
            i_data     <= '0;
            d_rd_data  <= '0;
        end else begin
            state_reg  <= state_next;
            k_reg      <= k_next;
            who_reg    <= who_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            asm_reg    <= asm_next;
            mem_en     <= mem_en_next;
            mem_we     <= mem_we_next;
            mem_addr   <= mem_addr_next;
            mem_wdata  <= mem_wdata_next;
            i_valid    <= i_valid_next;
            d_rd_valid <= d_rd_valid_next;
            d_wr_done  <= d_wr_done_next;
            i_data     <= i_data_next;
            d_rd_data  <= d_rd_data_next;
        end
    end

endmodule
